mem_arbiter: RTL and testbench

Two-port to single-port memory arbiter between the core's instruction-fetch and data ports and one shared single-port memory. It lets the core run against a single-ported RAM model or macro instead of a true dual-port memory. Data accesses win by default. A bounded starvation counter guarantees fetch forward progress. Responses are routed back to the port that issued them, using one tracked outstanding access.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 104 ++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port to single-port memory arbiter.
package mem_arb_pkg;

  localparam int STARVE_W = 4;

  // Which port, if any, had a request accepted in the previous cycle.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IM_RESP = 2'd1,
    DM_RESP = 2'd2
  } resp_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_IM   = 2'd1,
    GNT_DM   = 2'd2
  } grant_e;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between the fetch (IM) and data (DM) ports.
// Data wins by default; a bounded starvation counter forces fetch through.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        im_en_i,
  input  logic [31:0] im_addr_i,
  output logic [31:0] im_dout_o,
  output logic        im_busy_o,
  input  logic        dm_en_i,
  input  logic        dm_wen_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_din_i,
  output logic [31:0] dm_dout_o,
  output logic        dm_busy_o,
  output logic        mem_en_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_din_o,
  input  logic [31:0] mem_dout_i,
  input  logic        mem_busy_i,
  output logic [1:0]  resp_q_o,
  output logic [3:0]  starve_cnt_o
);

  // Handshake: a requester holds en/addr/wen/din until the first cycle its
  // busy is low; that cycle completes the access and returns read data.
  // A request is accepted when granted while mem_busy_i is low.

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  resp_e               resp_q, resp_d;
  logic [STARVE_W-1:0] starve_cnt, starve_d;
  grant_e              gnt;
  logic                im_elig, dm_elig, accept;

  // State register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      resp_q     <= IDLE;
      starve_cnt <= '0;
    end else begin
      resp_q     <= resp_d;
      starve_cnt <= starve_d;
    end
  end

  // A port completing this cycle is not eligible, so it cannot be re-granted
  // the same request it is just finishing.
  always_comb begin
    im_elig = im_en_i && (resp_q != IM_RESP);
    dm_elig = dm_en_i && (resp_q != DM_RESP);
    gnt     = GNT_NONE;
    if (dm_elig && !(im_elig && (starve_cnt == LIMIT))) gnt = GNT_DM;
    else if (im_elig)                                   gnt = GNT_IM;
    accept  = (gnt != GNT_NONE) && !mem_busy_i;
  end

  // Next-state logic.
  always_comb begin
    resp_d   = IDLE;
    starve_d = starve_cnt;
    if (accept) resp_d = (gnt == GNT_IM) ? IM_RESP : DM_RESP;
    if (!im_en_i) begin
      starve_d = '0;
    end else if (accept && (gnt == GNT_IM)) begin
      starve_d = '0;
    end else if (accept && (gnt == GNT_DM) && im_elig && (starve_cnt < LIMIT)) begin
      starve_d = starve_cnt + 1'b1;
    end
  end

  // Output logic: grant mux toward memory, response demux toward the ports.
  always_comb begin
    mem_en_o   = 1'b0;
    mem_wen_o  = 1'b0;
    mem_addr_o = '0;
    mem_din_o  = '0;
    case (gnt)
      GNT_IM: begin
        mem_en_o   = 1'b1;
        mem_addr_o = im_addr_i;
      end
      GNT_DM: begin
        mem_en_o   = 1'b1;
        mem_wen_o  = dm_wen_i;
        mem_addr_o = dm_addr_i;
        mem_din_o  = dm_din_i;
      end
      default: ;
    endcase
    im_busy_o    = im_en_i && (resp_q != IM_RESP);
    dm_busy_o    = dm_en_i && (resp_q != DM_RESP);
    im_dout_o    = (resp_q == IM_RESP) ? mem_dout_i : '0;
    dm_dout_o    = (resp_q == DM_RESP) ? mem_dout_i : '0;
    resp_q_o     = resp_q;
    starve_cnt_o = starve_cnt;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level arbitration model
// predicts every grant and pushes expected responses into per-port queues.
module tb_mem_arbiter;

  localparam int LIMIT    = 2;
  localparam int N_CYCLES = 4000;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n_i;
  logic        im_en_i, dm_en_i, dm_wen_i, mem_busy_i;
  logic [31:0] im_addr_i, dm_addr_i, dm_din_i, mem_dout_i;
  logic [31:0] im_dout_o, dm_dout_o, mem_addr_o, mem_din_o;
  logic        im_busy_o, dm_busy_o, mem_en_o, mem_wen_o;
  logic [1:0]  resp_q_o;
  logic [3:0]  starve_cnt_o;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk_i(clk), .rst_n_i(rst_n_i),
    .im_en_i(im_en_i), .im_addr_i(im_addr_i), .im_dout_o(im_dout_o), .im_busy_o(im_busy_o),
    .dm_en_i(dm_en_i), .dm_wen_i(dm_wen_i), .dm_addr_i(dm_addr_i), .dm_din_i(dm_din_i),
    .dm_dout_o(dm_dout_o), .dm_busy_o(dm_busy_o),
    .mem_en_o(mem_en_o), .mem_wen_o(mem_wen_o), .mem_addr_o(mem_addr_o), .mem_din_o(mem_din_o),
    .mem_dout_i(mem_dout_i), .mem_busy_i(mem_busy_i),
    .resp_q_o(resp_q_o), .starve_cnt_o(starve_cnt_o)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [32:0] im_exp_q[$];   // bit 32 marks a write (data don't-care)
  logic [32:0] dm_exp_q[$];
  logic [31:0] tb_mem  [logic [31:0]];   // the memory the DUT talks to
  logic [31:0] ref_mem [logic [31:0]];   // the model's view of memory contents
  bit im_done = 0, dm_done = 0;
  int im_pops = 0, dm_pops = 0, rst_events = 0;

  // Reference model: who completes next cycle (0 none, 1 fetch, 2 data) and how
  // many data grants fetch has waited behind.
  int last_port = 0;
  int dm_run    = 0;
  int m_g = 0;
  bit m_acc = 0, m_im_want = 0, m_im_en = 0;
  bit s_en = 0, s_wen = 0, s_busy = 0, s_rst = 0;
  logic [31:0] s_addr = '0, s_din = '0;
  int rst_hold = 4;
  int busy_left = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h8000_0000 + 32'($urandom_range(0, 15)) * 32'd4;
  endfunction

  // ---------------- model check (negedge) ----------------
  task automatic model_check();
    bit im_want, dm_want;
    int g;
    logic [31:0] exp_addr, exp_din;
    im_want = im_en_i && (last_port != 1);
    dm_want = dm_en_i && (last_port != 2);
    g = 0;
    if (dm_want && !(im_want && dm_run >= LIMIT)) g = 2;
    else if (im_want) g = 1;
    exp_addr = (g == 1) ? im_addr_i : (g == 2) ? dm_addr_i : 32'h0;
    exp_din  = (g == 2) ? dm_din_i : 32'h0;
    chk("mem_en",     {31'h0, mem_en_o},  {31'h0, g != 0});
    chk("mem_wen",    {31'h0, mem_wen_o}, {31'h0, (g == 2) && dm_wen_i});
    chk("mem_addr",   mem_addr_o, exp_addr);
    chk("mem_din",    mem_din_o,  exp_din);
    chk("im_busy",    {31'h0, im_busy_o}, {31'h0, im_want});
    chk("dm_busy",    {31'h0, dm_busy_o}, {31'h0, dm_want});
    chk("resp_state", {30'h0, resp_q_o},  32'(last_port));
    chk("starve_cnt", {28'h0, starve_cnt_o}, 32'(dm_run));
    if (last_port != 1) chk("im_dout_idle", im_dout_o, 32'h0);
    if (last_port != 2) chk("dm_dout_idle", dm_dout_o, 32'h0);
    m_g       = g;
    m_im_want = im_want;
    m_im_en   = im_en_i;
    m_acc     = (g != 0) && !mem_busy_i && rst_n_i;
    if (m_acc) begin
      if (g == 1) im_exp_q.push_back({1'b0, ref_rd(im_addr_i)});
      else if (dm_wen_i) begin
        dm_exp_q.push_back({1'b1, 32'h0});
        ref_mem[dm_addr_i] = dm_din_i;
      end else dm_exp_q.push_back({1'b0, ref_rd(dm_addr_i)});
    end
    s_en = mem_en_o; s_wen = mem_wen_o; s_addr = mem_addr_o; s_din = mem_din_o;
    s_busy = mem_busy_i; s_rst = rst_n_i;
  endtask

  // ---------------- monitor: pops on every completion ----------------
  always @(negedge clk) begin
    logic [32:0] e;
    im_done = 0;
    dm_done = 0;
    if (im_en_i && !im_busy_o) begin
      im_done = 1;
      if (im_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL im_unexpected_completion: got completion expected none at %0t", $time);
      end else begin
        e = im_exp_q.pop_front();
        im_pops++;
        chk("im_dout", im_dout_o, e[31:0]);
      end
    end
    if (dm_en_i && !dm_busy_o) begin
      dm_done = 1;
      if (dm_exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dm_unexpected_completion: got completion expected none at %0t", $time);
      end else begin
        e = dm_exp_q.pop_front();
        dm_pops++;
        if (!e[32]) chk("dm_dout", dm_dout_o, e[31:0]);
      end
    end
  end

  // ---------------- driver tasks (posedge + 1) ----------------
  task automatic model_update();
    if (!rst_n_i) begin
      last_port = 0;
      dm_run    = 0;
    end else begin
      if (!m_im_en) dm_run = 0;
      else if (m_acc && m_g == 1) dm_run = 0;
      else if (m_acc && m_g == 2 && m_im_want && dm_run < LIMIT) dm_run++;
      last_port = m_acc ? m_g : 0;
    end
  endtask

  task automatic drive_memory();
    if (s_en && !s_busy && s_rst) begin
      if (s_wen) begin
        tb_mem[s_addr] = s_din;
        mem_dout_i = $urandom;
      end else mem_dout_i = tb_mem.exists(s_addr) ? tb_mem[s_addr] : 32'h0;
    end else mem_dout_i = $urandom;
    if (busy_left > 0) begin
      mem_busy_i = 1'b1;
      busy_left--;
    end else if ($urandom_range(0, 99) < 6) begin
      mem_busy_i = 1'b1;
      busy_left  = 2;
    end else mem_busy_i = ($urandom_range(0, 99) < 15);
  endtask

  task automatic drive_requesters();
    if (!im_en_i || im_done) begin
      im_en_i   = ($urandom_range(0, 99) < 90);
      im_addr_i = rand_addr();
    end
    if (!dm_en_i || dm_done) begin
      dm_en_i   = ($urandom_range(0, 99) < 75);
      dm_wen_i  = ($urandom_range(0, 1) == 1);
      dm_addr_i = rand_addr();
      dm_din_i  = $urandom;
    end
  endtask

  task automatic drive_reset(input int cyc);
    if (rst_hold > 0) begin
      rst_hold--;
      if (rst_hold == 0) rst_n_i = 1'b1;
    end else if (cyc > 50 && rst_events < 6 && m_acc && m_g == 2 &&
                 $urandom_range(0, 99) < 20) begin
      // Drop the outstanding data access in the cycle it would complete.
      rst_n_i   = 1'b0;
      rst_hold  = 1;
      last_port = 0;
      dm_run    = 0;
      im_exp_q.delete();
      dm_exp_q.delete();
      rst_events++;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n_i    = 1'b0;
    mem_busy_i = 1'b0;
    mem_dout_i = 32'h0;
    im_en_i    = 1'b1;
    im_addr_i  = 32'h8000_0000;
    dm_en_i    = 1'b1;
    dm_wen_i   = 1'b0;
    dm_addr_i  = 32'h8000_2000;
    dm_din_i   = 32'hCAFE_BABE;
    for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
      @(negedge clk);
      model_check();
      @(posedge clk);
      #1;
      model_update();
      drive_memory();
      drive_requesters();
      drive_reset(cyc);
    end
    @(negedge clk);
    chk("im_completions_seen", {31'h0, im_pops > 100}, 32'h1);
    chk("dm_completions_seen", {31'h0, dm_pops > 100}, 32'h1);
    chk("mid_access_resets",   {31'h0, rst_events > 0}, 32'h1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
